// File: rtl/multi_cycle_adder.sv
// Chunk-serial adder/subtractor: one CHUNK-bit slice per cycle with a registered carry,
// returning the result with carry and signed-overflow flags over a valid/ready handshake.
module multi_cycle_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8,
  parameter int unsigned INC   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              valid_q, valid_d;

  logic [CHUNK-1:0]  a_slice, b_slice;
  logic [CHUNK:0]    slice_sum;

  // Select the current slice of both operands and add it with the registered carry.
  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (cnt_q == CntW'(i)) begin
        a_slice = a_q[i*CHUNK +: CHUNK];
        b_slice = b_q[i*CHUNK +: CHUNK];
      end
    end
    slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry_q};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;

    unique case (state_q)
      StIdle: begin
        if (!flush && in_valid) begin
          a_d = in1;
          case (mode)
            2'b01:   b_d = WIDTH'(INC);
            2'b10:   b_d = ~in2;
            default: b_d = in2;
          endcase
          // Subtraction is A + ~B + 1.
          carry_d = (mode == 2'b10);
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          for (int unsigned i = 0; i < N; i++) begin
            if (cnt_q == CntW'(i)) res_d[i*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
          end
          carry_d = slice_sum[CHUNK];
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            cout_d  = slice_sum[CHUNK];
            ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_sum[CHUNK-1] != a_q[WIDTH-1]);
            valid_d = 1'b1;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (flush || out_ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out       = res_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_multi_cycle_adder.sv
// Bench for multi_cycle_adder: three instances (N=4, N=1, N=8) share stimulus and are
// checked against an arithmetic reference model, plus directed handshake/abort sequences.
module tb_multi_cycle_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in1, in2;
  logic [1:0]  mode;
  logic        in_valid, flush, out_ready;

  logic [31:0] dout   [3];
  logic        dcout  [3];
  logic        dovf   [3];
  logic        dvalid [3];
  logic        drdy   [3];

  int n_tests = 0;
  int n_fail  = 0;
  int exp_lat [3] = '{5, 2, 9};

  always #5 clk = ~clk;

  multi_cycle_adder #(.WIDTH(32), .CHUNK(8), .INC(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2), .mode(mode), .in_valid(in_valid),
    .in_ready(drdy[0]), .flush(flush), .out(dout[0]), .carry_out(dcout[0]),
    .overflow(dovf[0]), .out_valid(dvalid[0]), .out_ready(out_ready)
  );

  multi_cycle_adder #(.WIDTH(32), .CHUNK(32), .INC(4)) u_dut_n1 (
    .clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2), .mode(mode), .in_valid(in_valid),
    .in_ready(drdy[1]), .flush(flush), .out(dout[1]), .carry_out(dcout[1]),
    .overflow(dovf[1]), .out_valid(dvalid[1]), .out_ready(out_ready)
  );

  multi_cycle_adder #(.WIDTH(32), .CHUNK(4), .INC(4)) u_dut_n8 (
    .clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2), .mode(mode), .in_valid(in_valid),
    .in_ready(drdy[2]), .flush(flush), .out(dout[2]), .carry_out(dcout[2]),
    .overflow(dovf[2]), .out_valid(dvalid[2]), .out_ready(out_ready)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  m;
    logic [31:0] r;
    logic        c;
    logic        o;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain wide/signed arithmetic on the operation the mode selects.
  function automatic void ref_model(input logic [31:0] a, input logic [31:0] b,
                                    input logic [1:0] m, output logic [31:0] r,
                                    output logic c, output logic o);
    logic [31:0] op;
    longint      sr;
    op = (m == 2'b01) ? 32'd4 : b;
    if (m == 2'b10) begin
      r  = a - op;
      c  = (a >= op);
      sr = longint'($signed(a)) - longint'($signed(op));
    end else begin
      {c, r} = {1'b0, a} + {1'b0, op};
      sr     = longint'($signed(a)) + longint'($signed(op));
    end
    o = (sr > 64'sh7FFF_FFFF) || (sr < -64'sh8000_0000);
  endfunction

  // Entered and left at posedge+1. Inputs are scrambled after the accept edge.
  task automatic run_req(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                         input logic [31:0] er, input logic ec, input logic eo,
                         input string tag);
    int          lat [3];
    logic [31:0] r   [3];
    logic        c   [3];
    logic        o   [3];
    lat = '{-1, -1, -1};
    r   = '{32'h0, 32'h0, 32'h0};
    c   = '{1'b0, 1'b0, 1'b0};
    o   = '{1'b0, 1'b0, 1'b0};
    check({tag, " in_ready"}, 32'(drdy[0] & drdy[1] & drdy[2]), 32'd1);
    in1 = a; in2 = b; mode = m; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in1 = $urandom; in2 = $urandom; mode = 2'($urandom);
    for (int cy = 1; cy <= 11; cy++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        if (dvalid[k] && lat[k] < 0) begin
          lat[k] = cy + 1;
          r[k] = dout[k]; c[k] = dcout[k]; o[k] = dovf[k];
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s dut%0d latency", tag, k), 32'(lat[k]), 32'(exp_lat[k]));
      check($sformatf("%s dut%0d out", tag, k), r[k], er);
      check($sformatf("%s dut%0d carry_out", tag, k), 32'(c[k]), 32'(ec));
      check($sformatf("%s dut%0d overflow", tag, k), 32'(o[k]), 32'(eo));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb, rr;
    logic [1:0]  rm;
    logic        rc, ro, seen;
    logic [31:0] edge_vals [4] = '{32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};

    vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 2'b00, 32'h0000_0100, 1'b0, 1'b0};
    vecs[1] = '{32'h0040_0000, 32'hDEAD_BEEF, 2'b01, 32'h0040_0004, 1'b0, 1'b0};
    vecs[2] = '{32'h0000_0005, 32'h0000_0007, 2'b10, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[3] = '{32'h0000_0007, 32'h0000_0005, 2'b10, 32'h0000_0002, 1'b1, 1'b0};
    vecs[4] = '{32'h7FFF_FFFF, 32'h0000_0001, 2'b00, 32'h8000_0000, 1'b0, 1'b1};
    vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 32'h0000_0000, 1'b1, 1'b0};
    vecs[6] = '{32'h0000_0001, 32'h0000_0002, 2'b11, 32'h0000_0003, 1'b0, 1'b0};
    vecs[7] = '{32'h8000_0000, 32'h0000_0001, 2'b10, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[8] = '{32'h0000_0000, 32'h0000_0000, 2'b10, 32'h0000_0000, 1'b1, 1'b0};

    rst_n = 1'b0; in1 = '0; in2 = '0; mode = '0;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    #3;
    check("reset out", dout[0], 32'h0);
    check("reset carry_out", 32'(dcout[0]), 32'd0);
    check("reset overflow", 32'(dovf[0]), 32'd0);
    check("reset out_valid", 32'(dvalid[0]), 32'd0);
    check("reset in_ready", 32'(drdy[0]), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i])
      run_req(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].r, vecs[i].c, vecs[i].o,
              $sformatf("vec%0d", i));

    // Backpressure: result held for 10 cycles, requests refused while in DONE.
    in1 = 32'h1234_5678; in2 = 32'h1111_1111; mode = 2'b00; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; in1 = 32'hFFFF_0000; in2 = 32'h0F0F_0F0F;
    seen = 1'b0;
    for (int cy = 0; cy < 20 && !seen; cy++) begin
      @(posedge clk); #1;
      seen = dvalid[0];
    end
    check("bp out_valid seen", 32'(seen), 32'd1);
    in_valid = 1'b1;
    for (int cy = 0; cy < 10; cy++) begin
      check("bp hold out", dout[0], 32'h2345_6789);
      check("bp hold out_valid", 32'(dvalid[0]), 32'd1);
      check("bp hold in_ready", 32'(drdy[0]), 32'd0);
      check("bp hold carry_out", 32'(dcout[0]), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp release out_valid", 32'(dvalid[0]), 32'd0);
    check("bp release in_ready", 32'(drdy[0]), 32'd1);

    // Flush in the second BUSY cycle, then flush versus in_valid in IDLE.
    in1 = 32'h0101_0101; in2 = 32'h0202_0202; mode = 2'b00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush in_ready", 32'(drdy[0]), 32'd1);
    check("flush out_valid", 32'(dvalid[0]), 32'd0);
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush priority in_ready", 32'(drdy[0]), 32'd1);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (dvalid[0]) seen = 1'b1;
    end
    check("flush no out_valid", 32'(seen), 32'd0);
    run_req(32'h0000_00FF, 32'h0000_0001, 2'b00, 32'h0000_0100, 1'b0, 1'b0, "post-flush");

    // Reset asserted mid-BUSY clears outputs without a clock edge.
    in1 = 32'hA5A5_5A5A; in2 = 32'h0F0F_F0F0; mode = 2'b00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("async rst out", dout[0], 32'h0);
    check("async rst carry_out", 32'(dcout[0]), 32'd0);
    check("async rst overflow", 32'(dovf[0]), 32'd0);
    check("async rst out_valid", 32'(dvalid[0]), 32'd0);
    check("async rst in_ready", 32'(drdy[0]), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_req(32'h0000_0007, 32'h0000_0005, 2'b10, 32'h0000_0002, 1'b1, 1'b0, "post-reset");

    for (int i = 0; i < 1000; i++) begin
      ra = (i % 4 == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
      rb = (i % 5 == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
      rm = 2'($urandom_range(0, 3));
      ref_model(ra, rb, rm, rr, rc, ro);
      run_req(ra, rb, rm, rr, rc, ro, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
